// File: rtl/execute_m.sv
// Execute stage: forwarding muxes, single-cycle ALU, pipelined multiplier, restoring divider.
// Latency: ALU ops combinational; MUL* MUL_LAT cycles, DIV/REM D_WIDTH cycles, divide special cases 1 cycle.
// Backpressure: multi-cycle ops raise stall_e_o to hold F/D/E and bubble M; flush/rst abort at once.
module execute_m #(
  parameter int D_WIDTH = 32,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_e_i,
  input  logic               reg_write_e_i,
  input  logic               mem_write_e_i,
  input  logic [1:0]         result_src_e_i,
  input  logic [3:0]         alu_ctrl_e,
  input  logic               alu_src_e,
  input  logic [2:0]         funct3,
  input  logic               jalr,
  input  logic               m_op_e,
  input  logic [D_WIDTH-1:0] rd1_e,
  input  logic [D_WIDTH-1:0] rd2_e,
  input  logic [D_WIDTH-1:0] pc_e,
  input  logic [D_WIDTH-1:0] imm_ext_e,
  input  logic [D_WIDTH-1:0] pc_plus_4e_i,
  input  logic [4:0]         rd_e_i,
  input  logic [1:0]         fwd_a_e,
  input  logic [1:0]         fwd_b_e,
  input  logic [D_WIDTH-1:0] result_w,
  input  logic [D_WIDTH-1:0] alu_result_m,
  output logic               stall_e_o,
  output logic               zero_e,
  output logic               reg_write_e_o,
  output logic               mem_write_e_o,
  output logic [1:0]         result_src_e_o,
  output logic [D_WIDTH-1:0] alu_result,
  output logic [D_WIDTH-1:0] write_data_e,
  output logic [D_WIDTH-1:0] pc_plus_4e_o,
  output logic [D_WIDTH-1:0] pc_target_e,
  output logic [4:0]         rd_e_o
);

  localparam int CW  = $clog2(D_WIDTH + 1);
  localparam int SHW = $clog2(D_WIDTH);
  localparam int MW  = 2 * D_WIDTH;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  localparam logic [D_WIDTH-1:0] INT_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt, cnt_nxt;
  logic               kill, stall, start, step_en;

  logic [D_WIDTH-1:0] src_a, fwd_b, src_b, alu_out, m_res;

  // latched M operands and divider state
  logic [D_WIDTH-1:0] op_a, op_b, rem_r, quot_r, dvs_r;
  logic [2:0]         f3_r;
  logic               spec_r;

  // multiplier
  logic               mul_a_sgn, mul_b_sgn;
  logic signed [D_WIDTH:0] mul_a, mul_b;
  logic [MW-1:0]      mprod;
  logic [MW-1:0]      mul_pipe [MUL_LAT];

  // divider datapath
  logic               div_sgn, div_zero, div_ovf;
  logic [D_WIDTH-1:0] a_mag, b_mag;
  logic [D_WIDTH-1:0] div_rem_in, div_q_in, div_d_in, rem_step, q_step;
  logic [D_WIDTH:0]   div_shift, div_diff;

  assign kill = flush_e_i | rst;

  // forwarding muxes: 00 and 11 both take the register file value
  always_comb begin
    case (fwd_a_e)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
    case (fwd_b_e)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_result_m;
      default: fwd_b = rd2_e;
    endcase
  end

  assign src_b        = alu_src_e ? imm_ext_e : fwd_b;
  assign write_data_e = fwd_b;

  // single-cycle ALU
  always_comb begin
    alu_out = '0;
    case (alu_ctrl_e)
      ALU_ADD:  alu_out = src_a + src_b;
      ALU_SUB:  alu_out = src_a - src_b;
      ALU_AND:  alu_out = src_a & src_b;
      ALU_OR:   alu_out = src_a | src_b;
      ALU_XOR:  alu_out = src_a ^ src_b;
      ALU_SLT:  alu_out[0] = $signed(src_a) < $signed(src_b);
      ALU_SLTU: alu_out[0] = src_a < src_b;
      ALU_SLL:  alu_out = src_a << src_b[SHW-1:0];
      ALU_SRL:  alu_out = src_a >> src_b[SHW-1:0];
      ALU_SRA:  alu_out = $signed(src_a) >>> src_b[SHW-1:0];
      ALU_LUI:  alu_out = src_b;
      default:  alu_out = '0;
    endcase
  end

  assign zero_e = (alu_out == '0);

  // Multiplier operands are taken live; stage 0 captures the product in the
  // issue cycle, so the last stage holds it exactly MUL_LAT edges later.
  assign mul_a_sgn = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
  assign mul_b_sgn = (funct3[1:0] == 2'b01);
  assign mul_a     = {mul_a_sgn & src_a[D_WIDTH-1], src_a};
  assign mul_b     = {mul_b_sgn & fwd_b[D_WIDTH-1], fwd_b};
  assign mprod     = MW'(mul_a) * MW'(mul_b);

  // multiplier register stages
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MUL_LAT; k++) mul_pipe[k] <= '0;
    end else begin
      mul_pipe[0] <= mprod;
      for (int k = 1; k < MUL_LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
    end
  end

  // divider operand magnitudes and special-case detection (issue cycle)
  assign div_sgn  = ~funct3[0];
  assign a_mag    = (div_sgn && src_a[D_WIDTH-1]) ? -src_a : src_a;
  assign b_mag    = (div_sgn && fwd_b[D_WIDTH-1]) ? -fwd_b : fwd_b;
  assign div_zero = (fwd_b == '0);
  assign div_ovf  = div_sgn && (src_a == INT_MIN) && (fwd_b == '1);

  // One restoring step. The first step runs in the issue cycle on live
  // operands so D_WIDTH quotient bits are done by the time DONE is reached.
  always_comb begin
    if (state == S_IDLE) begin
      div_rem_in = '0;
      div_q_in   = a_mag;
      div_d_in   = b_mag;
    end else begin
      div_rem_in = rem_r;
      div_q_in   = quot_r;
      div_d_in   = dvs_r;
    end
    div_shift = {div_rem_in, div_q_in[D_WIDTH-1]};
    div_diff  = div_shift - {1'b0, div_d_in};
    if (!div_diff[D_WIDTH]) begin
      rem_step = div_diff[D_WIDTH-1:0];
      q_step   = {div_q_in[D_WIDTH-2:0], 1'b1};
    end else begin
      rem_step = div_shift[D_WIDTH-1:0];
      q_step   = {div_q_in[D_WIDTH-2:0], 1'b0};
    end
  end

  // FSM state and counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next state, stall and datapath enables; kill wins in every state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    start     = 1'b0;
    step_en   = 1'b0;
    if (kill) begin
      state_nxt = S_IDLE;
      cnt_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (m_op_e) begin
            stall = 1'b1;
            start = 1'b1;
            if (!funct3[2]) begin
              if (MUL_LAT == 1) begin
                state_nxt = S_DONE;
              end else begin
                state_nxt = S_MUL;
                cnt_nxt   = CW'(MUL_LAT - 1);
              end
            end else if (div_zero || div_ovf) begin
              state_nxt = S_DONE;
            end else begin
              state_nxt = S_DIV;
              cnt_nxt   = CW'(D_WIDTH - 1);
            end
          end
        end
        S_MUL: begin
          stall   = 1'b1;
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) state_nxt = S_DONE;
        end
        S_DIV: begin
          stall   = 1'b1;
          step_en = 1'b1;
          cnt_nxt = cnt - CW'(1);
          if (cnt == CW'(1)) state_nxt = S_DONE;
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // operand latch at issue, then one divider step per DIV cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      f3_r   <= '0;
      spec_r <= 1'b0;
      rem_r  <= '0;
      quot_r <= '0;
      dvs_r  <= '0;
    end else if (start) begin
      op_a   <= src_a;
      op_b   <= fwd_b;
      f3_r   <= funct3;
      spec_r <= funct3[2] & (div_zero | div_ovf);
      rem_r  <= rem_step;
      quot_r <= q_step;
      dvs_r  <= b_mag;
    end else if (step_en) begin
      rem_r  <= rem_step;
      quot_r <= q_step;
    end
  end

  // final M result: half select for multiplies, sign fix-up or special value for divides
  always_comb begin
    logic neg_q, neg_r;
    logic [D_WIDTH-1:0] q_fix, r_fix;
    neg_q = ~f3_r[0] & (op_a[D_WIDTH-1] ^ op_b[D_WIDTH-1]);
    neg_r = ~f3_r[0] & op_a[D_WIDTH-1];
    if (spec_r) begin
      q_fix = (op_b == '0) ? '1 : op_a;
      r_fix = (op_b == '0) ? op_a : '0;
    end else begin
      q_fix = neg_q ? -quot_r : quot_r;
      r_fix = neg_r ? -rem_r : rem_r;
    end
    if (f3_r[2]) m_res = f3_r[1] ? r_fix : q_fix;
    else if (f3_r[1:0] == 2'b00) m_res = mul_pipe[MUL_LAT-1][D_WIDTH-1:0];
    else m_res = mul_pipe[MUL_LAT-1][MW-1:D_WIDTH];
  end

  assign stall_e_o      = stall;
  assign reg_write_e_o  = reg_write_e_i & ~stall & ~kill;
  assign mem_write_e_o  = mem_write_e_i & ~stall & ~kill;
  assign result_src_e_o = result_src_e_i;
  assign alu_result     = (state == S_DONE) ? m_res : alu_out;
  assign pc_target_e    = jalr ? alu_result : (pc_e + imm_ext_e);
  assign pc_plus_4e_o   = pc_plus_4e_i;
  assign rd_e_o         = rd_e_i;

endmodule

// File: tb/tb_execute_m.sv
// Randomized bench for execute_m against a behavioural arithmetic model.
// Each M op is held in E for its modelled latency with forwarding inputs scrambled.
// Flush and reset mid-divide are checked for bubble and prompt return to idle.
module tb_execute_m;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, flush_e_i, reg_write_e_i, mem_write_e_i, alu_src_e, jalr, m_op_e;
  logic [1:0]  result_src_e_i, fwd_a_e, fwd_b_e;
  logic [3:0]  alu_ctrl_e;
  logic [2:0]  funct3;
  logic [31:0] rd1_e, rd2_e, pc_e, imm_ext_e, pc_plus_4e_i, result_w, alu_result_m;
  logic [4:0]  rd_e_i;
  logic        stall_e_o, zero_e, reg_write_e_o, mem_write_e_o;
  logic [1:0]  result_src_e_o;
  logic [31:0] alu_result, write_data_e, pc_plus_4e_o, pc_target_e;
  logic [4:0]  rd_e_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_m #(.D_WIDTH(32), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .flush_e_i(flush_e_i),
    .reg_write_e_i(reg_write_e_i), .mem_write_e_i(mem_write_e_i),
    .result_src_e_i(result_src_e_i), .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e),
    .funct3(funct3), .jalr(jalr), .m_op_e(m_op_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .imm_ext_e(imm_ext_e),
    .pc_plus_4e_i(pc_plus_4e_i), .rd_e_i(rd_e_i),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .result_w(result_w), .alu_result_m(alu_result_m),
    .stall_e_o(stall_e_o), .zero_e(zero_e), .reg_write_e_o(reg_write_e_o),
    .mem_write_e_o(mem_write_e_o), .result_src_e_o(result_src_e_o),
    .alu_result(alu_result), .write_data_e(write_data_e), .pc_plus_4e_o(pc_plus_4e_o),
    .pc_target_e(pc_target_e), .rd_e_o(rd_e_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RV32 ALU semantics by operation name
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return $signed(a) >>> sh;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  // RV32M semantics using 64-bit integer arithmetic
  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = (sa * ub) >>> 32;
      3'd3: r = (ua * ub) >> 32;
      3'd4: r = (b == 0) ? -1 : (a == INT_MIN && b == 32'hFFFF_FFFF) ? ua : sa / sb;
      3'd5: r = (b == 0) ? -1 : ua / ub;
      3'd6: r = (b == 0) ? ua : (a == INT_MIN && b == 32'hFFFF_FFFF) ? 0 : sa % sb;
      default: r = (b == 0) ? ua : ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0) return 1;
    if (!f3[0] && a == INT_MIN && b == 32'hFFFF_FFFF) return 1;
    return 32;
  endfunction

  task automatic scramble();
    rd1_e = $urandom; rd2_e = $urandom; result_w = $urandom; alu_result_m = $urandom;
    fwd_a_e = 2'($urandom_range(0, 3)); fwd_b_e = 2'($urandom_range(0, 3));
  endtask

  // ALU instruction: drive at posedge+1, check at negedge, return at next posedge+1
  task automatic drive_alu(input string tag, input logic [3:0] op, input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] imm, input logic [1:0] fa, input logic [1:0] fb,
                           input logic [31:0] rw, input logic [31:0] am, input logic asrc, input logic jv);
    logic [31:0] a, bv, b, exp, tgt;
    logic rwe;
    rwe = 1'($urandom_range(0, 1));
    m_op_e = 1'b0; alu_ctrl_e = op; rd1_e = r1; rd2_e = r2; imm_ext_e = imm;
    fwd_a_e = fa; fwd_b_e = fb; result_w = rw; alu_result_m = am; alu_src_e = asrc; jalr = jv;
    reg_write_e_i = rwe; mem_write_e_i = ~rwe; pc_e = $urandom; rd_e_i = 5'($urandom);
    funct3 = 3'($urandom_range(0, 7));
    a   = (fa == 2'b01) ? rw : (fa == 2'b10) ? am : r1;
    bv  = (fb == 2'b01) ? rw : (fb == 2'b10) ? am : r2;
    b   = asrc ? imm : bv;
    exp = ref_alu(op, a, b);
    tgt = jv ? exp : pc_e + imm;
    @(negedge clk);
    check({tag, "_res"}, alu_result, exp);
    check({tag, "_wd"}, write_data_e, bv);
    check({tag, "_ctl"}, {stall_e_o, reg_write_e_o, mem_write_e_o, zero_e},
          {1'b0, rwe, ~rwe, exp == 32'd0});
    check({tag, "_tgt"}, pc_target_e, tgt);
    check({tag, "_rd"}, rd_e_o, rd_e_i);
    @(posedge clk); #1;
  endtask

  // M instruction: operands delivered through random, distinct forwarding sources
  task automatic run_m(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int n, sa, sb;
    logic [31:0] exp;
    exp = ref_m(f3, a, b);
    n   = ref_lat(f3, a, b);
    scramble();
    sa = $urandom_range(0, 2);
    sb = (sa + 1 + $urandom_range(0, 1)) % 3;
    case (sa)
      1: begin fwd_a_e = 2'b01; result_w = a; end
      2: begin fwd_a_e = 2'b10; alu_result_m = a; end
      default: begin fwd_a_e = $urandom_range(0, 1) ? 2'b11 : 2'b00; rd1_e = a; end
    endcase
    case (sb)
      1: begin fwd_b_e = 2'b01; result_w = b; end
      2: begin fwd_b_e = 2'b10; alu_result_m = b; end
      default: begin fwd_b_e = $urandom_range(0, 1) ? 2'b11 : 2'b00; rd2_e = b; end
    endcase
    m_op_e = 1'b1; funct3 = f3; alu_src_e = 1'b0; reg_write_e_i = 1'b1; mem_write_e_i = 1'b0;
    jalr = 1'b0; alu_ctrl_e = 4'($urandom_range(0, 10));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check({tag, "_stall"}, stall_e_o, 1'b1);
      check({tag, "_bubble"}, {reg_write_e_o, mem_write_e_o}, 2'b00);
      @(posedge clk); #1;
      scramble();
    end
    @(negedge clk);
    check({tag, "_stall_end"}, stall_e_o, 1'b0);
    check({tag, "_res"}, alu_result, exp);
    check({tag, "_we"}, reg_write_e_o, 1'b1);
    @(posedge clk); #1;
    m_op_e = 1'b0;
  endtask

  // abort a DIV at t+5 with flush or reset, then confirm the stage is idle
  task automatic abort_div(input string tag, input logic use_rst);
    scramble();
    fwd_a_e = 2'b00; fwd_b_e = 2'b00; rd1_e = 32'hFFFF_FFF9; rd2_e = 32'd2;
    m_op_e = 1'b1; funct3 = 3'd4; reg_write_e_i = 1'b1; mem_write_e_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check({tag, "_stall"}, stall_e_o, 1'b1);
      @(posedge clk); #1;
    end
    if (use_rst) rst = 1'b1; else flush_e_i = 1'b1;
    mem_write_e_i = 1'b1;
    @(negedge clk);
    check({tag, "_kill_stall"}, stall_e_o, 1'b0);
    check({tag, "_kill_we"}, {reg_write_e_o, mem_write_e_o}, 2'b00);
    @(posedge clk); #1;
    rst = 1'b0; flush_e_i = 1'b0; m_op_e = 1'b0; mem_write_e_i = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, stall_e_o, 1'b0);
    @(posedge clk); #1;
    run_m({tag, "_after"}, 3'd0, 32'd6, 32'd7);
  endtask

  initial begin
    rst = 1'b1; flush_e_i = 1'b0; reg_write_e_i = 1'b1; mem_write_e_i = 1'b0;
    result_src_e_i = 2'b01; alu_ctrl_e = 4'd0; alu_src_e = 1'b0; funct3 = 3'd0; jalr = 1'b0;
    m_op_e = 1'b0; rd1_e = 32'd5; rd2_e = 32'd7; pc_e = 32'h100; imm_ext_e = 32'd0;
    pc_plus_4e_i = 32'h104; rd_e_i = 5'd3; fwd_a_e = 2'b00; fwd_b_e = 2'b00;
    result_w = 32'd0; alu_result_m = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_stall", stall_e_o, 1'b0);
    check("reset_res", alu_result, 32'd12);
    check("reset_pass", {result_src_e_o, pc_plus_4e_o}, {2'b01, 32'h104});
    @(posedge clk); #1;

    // directed ALU and forwarding
    drive_alu("add", 4'd0, 32'd5, 32'd7, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    drive_alu("addi_fwd", 4'd0, 32'd1, 32'd0, 32'd1, 2'b10, 2'b00, 32'd0, 32'd9, 1'b1, 1'b0);
    drive_alu("store_fwd", 4'd0, 32'd4, 32'd0, 32'd8, 2'b00, 2'b01, 32'h55, 32'd0, 1'b1, 1'b0);
    drive_alu("sub_zero", 4'd1, 32'd9, 32'd9, 32'd0, 2'b00, 2'b11, 32'd0, 32'd0, 1'b0, 1'b0);
    drive_alu("jalr", 4'd0, 32'h1000, 32'd0, 32'h20, 2'b00, 2'b00, 32'd0, 32'd0, 1'b1, 1'b1);

    // directed M ops including divider special cases and back-to-back issue
    run_m("mulhu", 3'd3, 32'hFFFF_FFFF, 32'd3);
    run_m("mul", 3'd0, 32'hFFFF_FFFF, 32'd3);
    run_m("mulh", 3'd1, 32'hFFFF_FFFF, 32'd3);
    run_m("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_m("div", 3'd4, 32'hFFFF_FFF9, 32'd2);
    run_m("rem", 3'd6, 32'hFFFF_FFF9, 32'd2);
    run_m("divu", 3'd5, 32'd100, 32'd7);
    run_m("remu", 3'd7, 32'd100, 32'd7);
    run_m("divu0", 3'd5, 32'd100, 32'd0);
    run_m("remu0", 3'd7, 32'd100, 32'd0);
    run_m("div_ovf", 3'd4, INT_MIN, 32'hFFFF_FFFF);
    run_m("rem_ovf", 3'd6, INT_MIN, 32'hFFFF_FFFF);
    run_m("divu_big", 3'd5, INT_MIN, 32'hFFFF_FFFF);

    abort_div("flush", 1'b0);
    abort_div("rst", 1'b1);

    // randomized mix
    for (int it = 0; it < 40; it++) begin
      logic [31:0] a, b;
      int kind;
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        drive_alu("rnd_alu", 4'($urandom_range(0, 10)), $urandom, $urandom, $urandom,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else begin
        a = $urandom; b = $urandom;
        case ($urandom_range(0, 7))
          0: b = 32'd0;
          1: begin a = INT_MIN; b = 32'hFFFF_FFFF; end
          2: begin a = -32'($urandom_range(0, 50)); b = 32'($urandom_range(1, 9)); end
          3: b = -32'($urandom_range(1, 9));
          default: ;
        endcase
        run_m("rnd_m", 3'($urandom_range(0, 7)), a, b);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
